// File: rtl/lane_packer_if.sv
// Beat/word stream bundle around the lane packer: packer is the slave, the
// upstream source and downstream sink together form the master side.
interface lane_packer_if #(
  parameter int MAPPER_PARALLELISM = 8,
  parameter int DATA_WIDTH         = 8
);
  localparam int P  = MAPPER_PARALLELISM;
  localparam int L  = $clog2(P);
  localparam int DW = DATA_WIDTH;

  logic            in_valid;
  logic            in_ready;
  logic [P-1:0]    in_mask;
  logic [P*L-1:0]  in_offset;
  logic [P*DW-1:0] in_data;
  logic            in_last;

  logic            out_valid;
  logic            out_ready;
  logic [P*DW-1:0] out_data;
  logic [L:0]      out_count;
  logic            out_last;

  modport slave (
    input  in_valid, in_mask, in_offset, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );

  modport master (
    output in_valid, in_mask, in_offset, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/lane_packer.sv
// Compacts masked lanes of incoming beats into dense P-lane output words.
// Optional LANE_PACKER_STATS_EN adds saturating word/frame pop counters.
module lane_packer #(
  parameter int MAPPER_PARALLELISM = 8,
  parameter int DATA_WIDTH         = 8
) (
  input  logic        clk,
  input  logic        rst,
  lane_packer_if.slave bus
`ifdef LANE_PACKER_STATS_EN
  ,
  output logic [31:0] stat_words,
  output logic [31:0] stat_frames
`endif
);
  localparam int P  = MAPPER_PARALLELISM;
  localparam int L  = $clog2(P);
  localparam int DW = DATA_WIDTH;
  localparam int D  = 2 * P - 1;
  localparam int FW = L + 1;
  localparam logic [FW-1:0] P_W = FW'(P);

  logic [DW-1:0] buf_q [D];
  logic [DW-1:0] buf_d [D];
  logic [DW-1:0] shifted_up [D];
  logic [DW-1:0] shifted [D];
  logic [DW-1:0] beat_lane [P];
  logic [FW-1:0] fill_q, fill_d;
  logic [FW-1:0] fill_s;
  logic          flush_q, flush_d;
  logic [L-1:0]  last_field;
  logic [L-1:0]  slot;
  logic [FW-1:0] beat_n;
  logic [FW-1:0] out_count;
  logic          out_valid, out_last;
  logic          accept, pop, in_ready;

  assign last_field = bus.in_offset[P*L-1 -: L];
  assign beat_n     = (last_field == '0 && bus.in_mask != '0) ? P_W : {1'b0, last_field};

  // Each kept lane lands at slot (inclusive prefix sum - 1) of its beat.
  always_comb begin
    slot = '0;
    for (int k = 0; k < P; k++) beat_lane[k] = '0;
    for (int i = 0; i < P; i++) begin
      if (bus.in_mask[i]) begin
        slot = bus.in_offset[L*i +: L] - L'(1);
        beat_lane[slot] = bus.in_data[DW*i +: DW];
      end
    end
  end

  assign out_count = (fill_q > P_W) ? P_W : fill_q;
  // A pending flush always blocks in_ready, so "no accept" is implied here.
  assign out_valid = (fill_q >= P_W) || flush_q;
  assign out_last  = flush_q && (fill_q <= P_W);
  assign pop       = out_valid && bus.out_ready;
  assign in_ready  = !flush_q && ((fill_q < P_W) || pop);
  assign accept    = bus.in_valid && in_ready;

  assign bus.out_valid = out_valid;
  assign bus.out_count = out_count;
  assign bus.out_last  = out_last;
  assign bus.in_ready  = in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_out
      assign bus.out_data[DW*gi +: DW] = (FW'(gi) < out_count) ? buf_q[gi] : '0;
    end
    // A pop that does not close the frame always removes exactly P entries.
    for (gi = 0; gi < D; gi++) begin : g_shift
      if (gi + P < D) begin : g_take
        assign shifted_up[gi] = buf_q[gi+P];
      end else begin : g_zero
        assign shifted_up[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    flush_d = flush_q;
    fill_s  = fill_q;
    for (int j = 0; j < D; j++) shifted[j] = buf_q[j];
    if (pop) begin
      if (out_last) begin
        flush_d = 1'b0;
        fill_s  = '0;
        for (int j = 0; j < D; j++) shifted[j] = '0;
      end else begin
        fill_s = fill_q - P_W;
        for (int j = 0; j < D; j++) shifted[j] = shifted_up[j];
      end
    end

    fill_d = fill_s;
    for (int j = 0; j < D; j++) buf_d[j] = shifted[j];
    if (accept) begin
      fill_d = fill_s + beat_n;
      for (int j = 0; j < D; j++) begin
        if (FW'(j) >= fill_s && FW'(j) < fill_s + beat_n)
          buf_d[j] = beat_lane[L'(FW'(j) - fill_s)];
      end
      if (bus.in_last) flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q  <= '0;
      flush_q <= 1'b0;
      for (int j = 0; j < D; j++) buf_q[j] <= '0;
    end else begin
      fill_q  <= fill_d;
      flush_q <= flush_d;
      for (int j = 0; j < D; j++) buf_q[j] <= buf_d[j];
    end
  end

`ifdef LANE_PACKER_STATS_EN
  logic [31:0] words_q, frames_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q  <= '0;
      frames_q <= '0;
    end else begin
      if (pop && words_q != '1) words_q <= words_q + 32'd1;
      if (pop && out_last && frames_q != '1) frames_q <= frames_q + 32'd1;
    end
  end

  assign stat_words  = words_q;
  assign stat_frames = frames_q;
`endif
endmodule

// File: tb/tb_lane_packer.sv
// Directed bench for lane_packer (P=8, DW=8) with a queue-based reference
// model checked every cycle plus literal expectations for key scenarios.
module tb_lane_packer;
  localparam int P  = 8;
  localparam int L  = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lane_packer_if #(.MAPPER_PARALLELISM(P), .DATA_WIDTH(DW)) bus ();

`ifdef LANE_PACKER_STATS_EN
  logic [31:0] stat_words, stat_frames;
`endif

  lane_packer #(.MAPPER_PARALLELISM(P), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef LANE_PACKER_STATS_EN
    ,
    .stat_words(stat_words),
    .stat_frames(stat_frames)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: packed entries in arrival order plus flush flag.
  logic [DW-1:0] mq[$];
  bit            mflush;
  int            m_words, m_frames;
  int            sz, e_cnt;
  bit            e_ov, e_last, e_pop, e_ir;
  logic [63:0]   e_data;

  logic [7:0] tmask [8] = '{8'h81, 8'h5A, 8'hFF, 8'h00, 8'h3C, 8'hE7, 8'h01, 8'hFE};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [P*L-1:0] prefix(input logic [P-1:0] m);
    logic [P*L-1:0] r;
    logic [L-1:0]   acc;
    acc = '0;
    r   = '0;
    for (int i = 0; i < P; i++) begin
      acc = acc + L'(m[i]);
      r[L*i +: L] = acc;
    end
    return r;
  endfunction

  function automatic logic [63:0] lanes(input logic [7:0] base);
    logic [63:0] r;
    for (int i = 0; i < P; i++) r[8*i +: 8] = base + 8'(i);
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send_beat(input logic [7:0] m, input logic [63:0] d, input logic l);
    int  waitc;
    bit  acc;
    waitc = 0;
    bus.in_valid  = 1'b1;
    bus.in_mask   = m;
    bus.in_offset = prefix(m);
    bus.in_data   = d;
    bus.in_last   = l;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc || waitc > 200) break;
      waitc++;
    end
    chk("send_timeout", (waitc > 200) ? 1 : 0, 0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((mq.size() != 0 || mflush) && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_timeout", (c >= 200) ? 1 : 0, 0);
  endtask

  // Per-cycle compare against the model, then advance the model past the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        mflush   = 1'b0;
        m_words  = 0;
        m_frames = 0;
      end else begin
        sz     = mq.size();
        e_ov   = (sz >= P) || mflush;
        e_cnt  = (sz < P) ? sz : P;
        e_last = mflush && (sz <= P);
        e_pop  = e_ov && bus.out_ready;
        e_ir   = !mflush && ((sz < P) || e_pop);
        e_data = '0;
        for (int k = 0; k < e_cnt; k++) e_data[8*k +: 8] = mq[k];
        chk("in_ready", bus.in_ready, e_ir);
        chk("out_valid", bus.out_valid, e_ov);
        if (e_ov) begin
          chk("out_count", bus.out_count, e_cnt);
          chk("out_data", bus.out_data, e_data);
          chk("out_last", bus.out_last, e_last);
        end
`ifdef LANE_PACKER_STATS_EN
        chk("stat_words", stat_words, m_words);
        chk("stat_frames", stat_frames, m_frames);
`endif
        if (e_pop) begin
          m_words++;
          if (e_last) begin
            m_frames++;
            mq.delete();
            mflush = 1'b0;
          end else begin
            repeat (P) void'(mq.pop_front());
          end
        end
        if (bus.in_valid && e_ir) begin
          for (int i = 0; i < P; i++)
            if (bus.in_mask[i]) mq.push_back(bus.in_data[8*i +: 8]);
          if (bus.in_last) mflush = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mask   = '0;
    bus.in_offset = '0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    @(posedge clk);
    #1;

    // Full beat passes straight through.
    bus.out_ready = 1'b1;
    send_beat(8'hFF, lanes(8'h10), 1'b0);
    $display("beat 0xFF -> count=%0d data=%h last=%0d", bus.out_count, bus.out_data, bus.out_last);
    chk("full_valid", bus.out_valid, 1);
    chk("full_count", bus.out_count, 8);
    chk("full_data", bus.out_data, 64'h1716151413121110);
    chk("full_last", bus.out_last, 0);

    // Two half beats merge into one word.
    send_beat(8'h0F, lanes(8'hA0), 1'b0);
    send_beat(8'hF0, lanes(8'hB0), 1'b0);
    $display("beats 0x0F,0xF0 -> count=%0d data=%h", bus.out_count, bus.out_data);
    chk("merge_count", bus.out_count, 8);
    chk("merge_data", bus.out_data, 64'hB7B6B5B4A3A2A1A0);

    // 3 + 6 + 1 entries with in_last: words of 8 then 2.
    send_beat(8'h07, lanes(8'hC0), 1'b0);
    send_beat(8'h3F, lanes(8'hD0), 1'b0);
    $display("beats 0x07,0x3F -> count=%0d data=%h", bus.out_count, bus.out_data);
    chk("frame_w1_count", bus.out_count, 8);
    chk("frame_w1_data", bus.out_data, 64'hD4D3D2D1D0C2C1C0);
    chk("frame_w1_last", bus.out_last, 0);
    send_beat(8'h01, lanes(8'hE0), 1'b1);
    $display("beat 0x01 last -> count=%0d data=%h last=%0d", bus.out_count, bus.out_data, bus.out_last);
    chk("frame_w2_count", bus.out_count, 2);
    chk("frame_w2_data", bus.out_data, 64'h000000000000E0D5);
    chk("frame_w2_last", bus.out_last, 1);
    drain();

    // Backpressure: held word, in_ready low, nothing lost.
    bus.out_ready = 1'b0;
    send_beat(8'hFF, lanes(8'hF0), 1'b0);
    fork
      begin
        send_beat(8'hFF, lanes(8'h20), 1'b0);
        send_beat(8'hFF, lanes(8'h30), 1'b0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          $display("stall: in_ready=%0d data=%h", bus.in_ready, bus.out_data);
          chk("stall_in_ready", bus.in_ready, 0);
          chk("stall_data", bus.out_data, 64'hF7F6F5F4F3F2F1F0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Empty beat with in_last on an empty buffer.
    send_beat(8'h00, lanes(8'h40), 1'b1);
    $display("beat 0x00 last -> count=%0d last=%0d", bus.out_count, bus.out_last);
    chk("empty_valid", bus.out_valid, 1);
    chk("empty_count", bus.out_count, 0);
    chk("empty_last", bus.out_last, 1);
    chk("empty_data", bus.out_data, 0);
    drain();

    // Reset with a partial frame and pending flush.
    bus.out_ready = 1'b0;
    send_beat(8'h1F, lanes(8'h50), 1'b1);
    chk("pre_rst_count", bus.out_count, 5);
    chk("pre_rst_data", bus.out_data, 64'h0000005453525150);
    chk("pre_rst_last", bus.out_last, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    $display("reset mid-frame -> out_valid=%0d in_ready=%0d", bus.out_valid, bus.in_ready);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_count", bus.out_count, 0);
`ifdef LANE_PACKER_STATS_EN
    chk("mid_rst_stat_words", stat_words, 0);
    chk("mid_rst_stat_frames", stat_frames, 0);
`endif
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Mixed masks with toggling out_ready, closed by in_last.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_beat(tmask[i], lanes(8'h60 + 8'(i * 8)), (i == 7) ? 1'b1 : 1'b0);
          $display("table beat %0d mask=%h", i, tmask[i]);
        end
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(posedge clk);
          #1 bus.out_ready = (c % 3 != 0) ? 1'b1 : 1'b0;
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Flush right after an exact multiple of P: zero-count closing word.
    send_beat(8'hFF, lanes(8'h80), 1'b0);
    send_beat(8'h00, lanes(8'h90), 1'b1);
    chk("mult_count", bus.out_count, 0);
    chk("mult_last", bus.out_last, 1);
    drain();

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lane_packer.md
LANE_PACKER -- requirements
Module: lane_packer

Interface
REQ-001 Parameter MAPPER_PARALLELISM, default 8: lane count P, a power of two, at least 2; L = $clog2(P).
REQ-002 Parameter DATA_WIDTH, default 8: width DW of each lane's data.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  an input beat is presented.
REQ-006 in_ready  output  1  the packer accepts the beat this cycle.
REQ-007 in_mask  input  P  per-lane valid mask for the beat.
REQ-008 in_offset  input  P*L  inclusive prefix sums of in_mask; field i (bits L*(i+1)-1 : L*i) = sum of in_mask[0..i], modulo P.
REQ-009 in_data  input  P*DW  lane data; lane i occupies bits DW*(i+1)-1 : DW*i.
REQ-010 in_last  input  1  the beat is the last of a frame.
REQ-011 out_valid  output  1  an output word is presented.
REQ-012 out_ready  input  1  downstream accepts the word.
REQ-013 out_data  output  P*DW  packed lanes; packed entry k sits in lane k.
REQ-014 out_count  output  L+1  number of valid packed lanes in out_data, 0..P.
REQ-015 out_last  output  1  the word closes the frame.

Function
REQ-016 Accept = in_valid && in_ready; Pop = out_valid && out_ready.
REQ-017 Beat count n = P when in_offset field P-1 is 0 and in_mask is nonzero; otherwise n = field P-1.
REQ-018 Lane i with in_mask[i]=1 goes to packed slot (field i - 1) mod P of the beat; lanes with in_mask[i]=0 are discarded.
REQ-019 The internal buffer holds 2P-1 entries in arrival order; fill is its occupancy, 0..2P-1.
REQ-020 On Accept, the beat's n packed entries are appended at positions fill..fill+n-1, in ascending lane order.
REQ-021 out_valid = (fill >= P) or (flush_pending and no Accept this cycle).
REQ-022 out_data lane k carries buffer entry k; lanes k >= out_count are driven to 0.
REQ-023 out_count = min(fill, P).
REQ-024 out_last = 1 only when flush_pending is set and fill <= P.
REQ-025 On Pop, the buffer shifts down by out_count and fill decreases by out_count.
REQ-026 When out_last is popped, flush_pending clears and fill becomes 0.
REQ-027 in_ready = !flush_pending and ((fill < P) or Pop). This is a combinational path from out_ready and is permitted.
REQ-028 Accept and Pop in the same cycle: the pop shift applies first, then the append, so fill_next = fill - out_count + n.
REQ-029 Accept with in_last=1 sets flush_pending at the next edge.
REQ-030 A frame with fill = 0 at flush emits one word with out_count=0 and out_last=1.
REQ-031 An all-zero in_mask beat is accepted, appends nothing, and still honours in_last.
REQ-032 Outputs are stable while out_valid=1 and out_ready=0.
REQ-033 A full beat is accepted every cycle with no bubbles while out_ready=1.

Reset
REQ-034 While rst=1 at a clock edge: fill=0, flush_pending=0, buffer cleared to 0.
REQ-035 After reset, out_valid=0, out_count=0, out_last=0, out_data=0, and in_ready=1.
REQ-036 Reset mid-frame discards all buffered entries and any pending flush; no word is emitted for them.

Configuration
REQ-037 Macro LANE_PACKER_STATS_EN: when defined, adds output stat_words (32 bits), which counts Pops, saturates at all-ones, and resets to 0.
REQ-038 Macro LANE_PACKER_STATS_EN: when defined, adds output stat_frames (32 bits), which counts Pops with out_last=1, saturates at all-ones, and resets to 0.
REQ-039 Without LANE_PACKER_STATS_EN, stat_words and stat_frames do not exist and all other behaviour is identical.

Verification (P=8, DW=8)
REQ-040 Beat with mask 0xFF, data lanes 0..7 = 0x10..0x17, out_ready=1 -> next cycle out_valid=1, out_count=8, out_data lanes = 0x10..0x17, out_last=0.
REQ-041 Beats with masks 0x0F then 0xF0 and distinct data -> one word with out_count=8: the four low lanes of beat 1, then the four high lanes of beat 2.
REQ-042 Masks 0x07, 0x3F, 0x01 with in_last on the third beat -> words with out_count 8 then 2, the second with out_last=1 and lanes 2..7 = 0.
REQ-043 Back-to-back 0xFF beats with out_ready held 0 for 3 cycles -> in_ready drops once fill >= 8, out_data is held stable, and no entry is lost or duplicated.
REQ-044 Beat with mask 0x00 and in_last=1 on an empty buffer -> a single word with out_count=0 and out_last=1.
REQ-045 rst asserted with fill=5 and flush_pending=1 -> next cycle out_valid=0, in_ready=1, and stat counters (if enabled) are 0.
